// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared state/mode encodings and constants for the packet arbiter
package axis_arb_pkg;

  // Largest supported number of upstream sources; internal muxes are padded to this size.
  localparam int MAX_SRC = 4;

  // Bit positions inside config_reg0.
  localparam int CFG_ARB_EN_BIT    = 0;
  localparam int CFG_PRIO_MODE_BIT = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

endpackage

// File: rtl/axis_arb_rr_picker.sv
// rtl/axis_arb_rr_picker.sv - combinational winner select (round-robin or fixed priority)
module axis_arb_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0] valid_i,
  input  logic [1:0]         last_i,
  input  prio_mode_e         mode_i,
  output logic [1:0]         winner_o,
  output logic               any_o
);

  logic [MAX_SRC-1:0] valid_pad;
  logic [2:0]         idx;
  logic               found;

  // Fixed mode takes the lowest valid index; round-robin scans upward starting just after last winner.
  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_SRC-1:0]   = valid_i;
    winner_o                 = '0;
    found                    = 1'b0;
    idx                      = '0;
    if (mode_i == PRIO_FIXED) begin
      for (int k = MAX_SRC - 1; k >= 0; k--) begin
        if (valid_pad[k]) begin
          winner_o = 2'(k);
        end
      end
    end else begin
      for (int k = 1; k <= MAX_SRC; k++) begin
        if (k <= NUM_SRC) begin
          // last_i < NUM_SRC and k <= NUM_SRC, so one subtraction is enough for the wrap.
          idx = {1'b0, last_i} + 3'(k);
          if (idx >= 3'(NUM_SRC)) begin
            idx = idx - 3'(NUM_SRC);
          end
          if (!found && valid_pad[idx[1:0]]) begin
            winner_o = idx[1:0];
            found    = 1'b1;
          end
        end
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/axis_st_packet_arbiter.sv
// rtl/axis_st_packet_arbiter.sv - packet-locked N:1 AXI-Stream arbiter; AXIS_ARB_PKT_CNT_EN adds per-source packet counters
module axis_st_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 128,
  parameter int NUM_SRC            = 2
) (
  input  logic                                 AXIS_ACLK,
  input  logic                                 AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                   S_AXIS_TVALID,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                   S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                   S_AXIS_TREADY,
  output logic                                 M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_TSTRB,
  output logic                                 M_AXIS_TLAST,
  input  logic                                 M_AXIS_TREADY,
  input  logic [31:0]                          config_reg0,
  output logic [1:0]                           grant_idx,
  output logic                                 busy,
  output logic [NUM_SRC*32-1:0]                pkt_cnt
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;

  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [SW-1:0] m_strb_q, m_strb_d;

  // Per-source views padded to MAX_SRC so the grant index can select without width games.
  logic [DW-1:0]      src_data [MAX_SRC];
  logic [SW-1:0]      src_strb [MAX_SRC];
  logic [MAX_SRC-1:0] src_valid;
  logic [MAX_SRC-1:0] src_last;

  logic       arb_en;
  prio_mode_e prio_mode;
  logic       unused_cfg;
  logic [1:0] pick_winner;
  logic       pick_any;
  logic       out_room;
  logic       sel_valid;
  logic       sel_last;
  logic       accept;

  assign arb_en     = config_reg0[CFG_ARB_EN_BIT];
  assign prio_mode  = prio_mode_e'(config_reg0[CFG_PRIO_MODE_BIT]);
  assign unused_cfg = ^config_reg0[31:2];

  for (genvar g = 0; g < MAX_SRC; g++) begin : g_src
    if (g < NUM_SRC) begin : g_real
      assign src_data[g]  = S_AXIS_TDATA[g*DW +: DW];
      assign src_strb[g]  = S_AXIS_TSTRB[g*SW +: SW];
      assign src_valid[g] = S_AXIS_TVALID[g];
      assign src_last[g]  = S_AXIS_TLAST[g];
    end else begin : g_pad
      assign src_data[g]  = '0;
      assign src_strb[g]  = '0;
      assign src_valid[g] = 1'b0;
      assign src_last[g]  = 1'b0;
    end
  end

  axis_arb_rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .valid_i  (S_AXIS_TVALID),
    .last_i   (last_q),
    .mode_i   (prio_mode),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  // The single output stage can take a beat when empty or when it drains this cycle.
  assign out_room  = !m_valid_q || M_AXIS_TREADY;
  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];
  assign accept    = (state_q == ST_LOCKED) && sel_valid && out_room;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_rdy
    assign S_AXIS_TREADY[g] = (state_q == ST_LOCKED) && (grant_q == 2'(g)) && out_room;
  end

  // Next-state: grant in IDLE, release the lock on an accepted TLAST, load or drain the output stage.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_last_d  = m_last_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en && pick_any) begin
          grant_d = pick_winner;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Enable and other sources are ignored here: a packet, once granted, always completes.
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = src_data[grant_q];
      m_strb_d  = src_strb[grant_q];
      m_last_d  = sel_last;
    end else if (M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  // State, grant pointer and output stage registers; reset drops any partial packet.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= 2'(NUM_SRC - 1);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_strb_q  <= m_strb_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    logic [31:0] cnt_q;
    // Count accepted end-of-packet beats of this source; wraps naturally at 2^32.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
        cnt_q <= '0;
      end else if (accept && sel_last && (grant_q == 2'(g))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign pkt_cnt[g*32 +: 32] = cnt_q;
  end
`else
  assign pkt_cnt = '0;
`endif

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TSTRB  = m_strb_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axis_st_packet_arbiter.sv
// tb/tb_axis_st_packet_arbiter.sv - randomized self-checking bench for axis_st_packet_arbiter
`timescale 1ns/1ps
module tb_axis_st_packet_arbiter;

  localparam int DW = 128;
  localparam int SW = DW / 8;
  localparam int NS = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    s_valid, s_last, s_ready;
  logic [NS*DW-1:0] s_data;
  logic [NS*SW-1:0] s_strb;
  logic             m_valid, m_last, m_ready;
  logic [DW-1:0]    m_data;
  logic [SW-1:0]    m_strb;
  logic [31:0]      cfg;
  logic [1:0]       grant;
  logic             busy;
  logic [NS*32-1:0] cnt;

  always #5 clk = ~clk;

  axis_st_packet_arbiter #(
    .C_AXIS_TDATA_WIDTH (DW),
    .NUM_SRC            (NS)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TSTRB  (s_strb),
    .S_AXIS_TLAST  (s_last),
    .S_AXIS_TREADY (s_ready),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TSTRB  (m_strb),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TREADY (m_ready),
    .config_reg0   (cfg),
    .grant_idx     (grant),
    .busy          (busy),
    .pkt_cnt       (cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  beat_t srcq [NS][$];
  beat_t expq [NS][$];
  bit    pres [NS];
  int    rate [NS];
  int    rdy_rate;
  int    stall_left;
  int    pkt_seq;

  int n_checks;
  int n_pass;

  bit            m_locked;
  int            m_grant;
  int            m_lastw;
  bit            e_ov;
  bit            e_ol;
  logic [DW-1:0] e_od;
  logic [SW-1:0] e_os;
  int unsigned   m_cnt [NS];
  int            hs_cnt [NS];

  bit in_pkt;
  int cur_src;
  int out_order [$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int model_pick(input bit fixed);
    int r;
    r = -1;
    if (fixed) begin
      for (int i = 0; i < NS; i++) if (r < 0 && pres[i]) r = i;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        int j;
        j = (m_lastw + k) % NS;
        if (r < 0 && pres[j]) r = j;
      end
    end
    return r;
  endfunction

  task automatic add_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {8'(src), 16'(pkt_seq), 8'(i), $urandom, $urandom, $urandom};
      b.s = SW'($urandom);
      b.l = (i == len - 1);
      srcq[src].push_back(b);
      expq[src].push_back(b);
    end
    pkt_seq++;
  endtask

  function automatic int exp_cnt(input int i);
`ifdef AXIS_ARB_PKT_CNT_EN
    return int'(m_cnt[i]);
`else
    return 0 * i;
`endif
  endfunction

  task automatic model_reset();
    m_locked = 0; m_grant = 0; m_lastw = NS - 1;
    e_ov = 0; e_ol = 0; e_od = '0; e_os = '0;
    for (int i = 0; i < NS; i++) begin
      m_cnt[i] = 0; pres[i] = 0;
      srcq[i].delete(); expq[i].delete();
    end
    in_pkt = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && $urandom_range(99, 0) < rate[i]) pres[i] = 1;
      s_valid[i] = pres[i];
      if (pres[i]) begin
        s_data[i*DW +: DW] = srcq[i][0].d;
        s_strb[i*SW +: SW] = srcq[i][0].s;
        s_last[i]          = srcq[i][0].l;
      end else begin
        s_data[i*DW +: DW] = '0;
        s_strb[i*SW +: SW] = '0;
        s_last[i]          = 1'b0;
      end
    end
    m_ready = ($urandom_range(99, 0) < rdy_rate);
    if (stall_left > 0 && e_ov && e_od[DW-1 -: 8] == 8'd0 && e_od[DW-25 -: 8] == 8'd2) begin
      m_ready = 1'b0;
      stall_left--;
    end
  endtask

  task automatic sb_take();
    int    src;
    int    avail;
    beat_t b;
    src = int'(m_data[DW-1 -: 8]);
    if (!in_pkt) begin
      in_pkt  = 1;
      cur_src = src;
      out_order.push_back(src);
    end
    check("no_interleave", DW'(src), DW'(cur_src));
    avail = (src < NS) ? expq[src].size() : 0;
    check("sb_beat_avail", DW'(avail != 0), DW'(1));
    if (avail != 0) begin
      b = expq[src].pop_front();
      check("sb_data", m_data, b.d);
      check("sb_strb", DW'(m_strb), DW'(b.s));
      check("sb_last", DW'(m_last), DW'(b.l));
    end
    if (m_last) in_pkt = 0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    logic [NS-1:0] exp_rdy;
    int            hs;
    int            w;
    check("m_tvalid", DW'(m_valid), DW'(e_ov));
    if (e_ov) begin
      check("m_tdata", m_data, e_od);
      check("m_tstrb", DW'(m_strb), DW'(e_os));
      check("m_tlast", DW'(m_last), DW'(e_ol));
    end
    check("busy", DW'(busy), DW'(m_locked));
    check("grant_idx", DW'(grant), DW'(m_grant));
    for (int i = 0; i < NS; i++) check("pkt_cnt", DW'(cnt[i*32 +: 32]), DW'(exp_cnt(i)));
    drive_inputs();
    #1;
    for (int i = 0; i < NS; i++) exp_rdy[i] = m_locked && (m_grant == i) && (!e_ov || m_ready);
    check("s_tready", DW'(s_ready), DW'(exp_rdy));
    if (m_valid && m_ready) sb_take();
    hs = -1;
    for (int i = 0; i < NS; i++) if (pres[i] && exp_rdy[i]) hs = i;
    if (hs >= 0) begin
      e_ov = 1; e_od = srcq[hs][0].d; e_os = srcq[hs][0].s; e_ol = srcq[hs][0].l;
    end else if (m_ready) begin
      e_ov = 0;
    end
    if (!m_locked) begin
      w = model_pick(cfg[1]);
      if (cfg[0] && w >= 0) begin
        m_grant  = w;
        m_locked = 1;
      end
    end else if (hs >= 0 && srcq[hs][0].l) begin
      m_locked = 0;
      m_lastw  = m_grant;
      m_cnt[m_grant]++;
    end
    if (hs >= 0) begin
      hs_cnt[hs]++;
      void'(srcq[hs].pop_front());
      pres[hs] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit pending();
    bit p;
    p = m_locked || e_ov;
    for (int i = 0; i < NS; i++) p = p || pres[i] || (srcq[i].size() > 0);
    return p;
  endfunction

  task automatic drain(input int budget);
    int c;
    c = 0;
    while (pending() && c < budget) begin
      step();
      c++;
    end
    check("drain_in_budget", DW'(c < budget), DW'(1));
    step();
    step();
    for (int i = 0; i < NS; i++) check("sb_all_delivered", DW'(expq[i].size()), DW'(0));
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_tvalid", DW'(m_valid), DW'(0));
    check("rst_m_tlast", DW'(m_last), DW'(0));
    check("rst_m_tdata", m_data, '0);
    check("rst_m_tstrb", DW'(m_strb), DW'(0));
    check("rst_s_tready", DW'(s_ready), DW'(0));
    check("rst_grant_idx", DW'(grant), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_pkt_cnt", DW'(cnt), DW'(0));
    model_reset();
    s_valid = '0; s_last = '0; s_data = '0; s_strb = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    n_checks = 0; n_pass = 0; pkt_seq = 0; stall_left = 0;
    rst_n = 1'b1; cfg = '0; m_ready = 1'b0;
    s_valid = '0; s_last = '0; s_data = '0; s_strb = '0;
    for (int i = 0; i < NS; i++) begin rate[i] = 100; hs_cnt[i] = 0; end
    rdy_rate = 100;
    model_reset();
    @(negedge clk);
    reset_now();

    // Round-robin, both sources backlogged with 4-beat packets.
    cfg = 32'h1;
    out_order.delete();
    for (int p = 0; p < 2; p++) begin add_pkt(0, 4); add_pkt(1, 4); end
    drain(300);
    check("rr_order_len", DW'(out_order.size()), DW'(4));
    for (int i = 0; i < 4; i++) if (i < out_order.size()) check("rr_order", DW'(out_order[i]), DW'(i % 2));

    // Fixed priority: every source-0 packet precedes source 1.
    cfg = 32'h3;
    out_order.delete();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, $urandom_range(5, 1));
      add_pkt(1, $urandom_range(5, 1));
    end
    drain(300);
    check("fixed_order_len", DW'(out_order.size()), DW'(6));
    for (int i = 0; i < 6; i++) if (i < out_order.size()) check("fixed_order", DW'(out_order[i]), DW'(i < 3 ? 0 : 1));

    // Backpressure while the third beat of an 8-beat packet sits in the output stage.
    cfg = 32'h1;
    stall_left = 3;
    add_pkt(0, 8);
    drain(300);
    check("stall_applied", DW'(stall_left), DW'(0));

    // Enable dropped mid-packet: packet still completes, no new grant while disabled.
    cfg = 32'h1;
    add_pkt(0, 6);
    base = hs_cnt[0]; c = 0;
    while (hs_cnt[0] - base < 2 && c < 100) begin step(); c++; end
    check("en_reach_beat2", DW'(c < 100), DW'(1));
    cfg = 32'h0;
    add_pkt(1, 3);
    for (int i = 0; i < 20; i++) step();
    check("en_pkt_completed", DW'(expq[0].size()), DW'(0));
    check("en_no_new_grant", DW'(expq[1].size()), DW'(3));
    check("en_idle", DW'(busy), DW'(0));
    cfg = 32'h1;
    drain(300);

    // Reset mid-packet, then the first grant restarts from the reset pointer.
    add_pkt(0, 8); add_pkt(1, 8);
    base = hs_cnt[0]; c = 0;
    while (hs_cnt[0] - base < 3 && c < 100) begin step(); c++; end
    check("rst_reach_beat3", DW'(c < 100), DW'(1));
    reset_now();
    out_order.delete();
    add_pkt(1, 2); add_pkt(0, 2);
    drain(300);
    check("post_rst_order_len", DW'(out_order.size()), DW'(2));
    if (out_order.size() > 0) check("post_rst_first_grant", DW'(out_order[0]), DW'(0));

    // Five packets from source 1 only, counters from a clean reset.
    @(negedge clk);
    reset_now();
    cfg = 32'h1;
    for (int p = 0; p < 5; p++) add_pkt(1, $urandom_range(4, 1));
    drain(300);
`ifdef AXIS_ARB_PKT_CNT_EN
    check("cnt_src1", DW'(cnt[63:32]), DW'(5));
`else
    check("cnt_src1", DW'(cnt[63:32]), DW'(0));
`endif
    check("cnt_src0", DW'(cnt[31:0]), DW'(0));

    // Random rounds: random mode, valid gaps, backpressure and enable toggling.
    for (int r = 0; r < 6; r++) begin
      cfg = {30'b0, 1'($urandom_range(1, 0)), 1'b1};
      for (int i = 0; i < NS; i++) begin
        rate[i] = $urandom_range(100, 20);
        for (int p = 0; p < $urandom_range(4, 1); p++) add_pkt(i, $urandom_range(8, 1));
      end
      rdy_rate = $urandom_range(100, 30);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(99, 0) < 5) cfg[0] = ~cfg[0];
        step();
      end
      cfg[0] = 1'b1;
      drain(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_st_packet_arbiter.md
AXIS_ST_PACKET_ARBITER -- requirements
Module: axis_st_packet_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 128, meaning stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_SRC, default 2, legal range 2..4, meaning number of upstream stream generators.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have AXIS_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have AXIS_ARESETN  in  1  asynchronous active-low reset.
REQ-006 SHALL have S_AXIS_TVALID  in  NUM_SRC  per-source valid.
REQ-007 SHALL have S_AXIS_TDATA  in  NUM_SRC*C_AXIS_TDATA_WIDTH  per-source data; source i occupies slice i.
REQ-008 SHALL have S_AXIS_TSTRB  in  NUM_SRC*C_AXIS_TDATA_WIDTH/8  per-source strobe.
REQ-009 SHALL have S_AXIS_TLAST  in  NUM_SRC  per-source end of packet.
REQ-010 SHALL have S_AXIS_TREADY  out  NUM_SRC  per-source ready.
REQ-011 SHALL have M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST (out) and M_AXIS_TREADY (in), toward XDMA.
REQ-012 SHALL have config_reg0  in  32  bit0 arb_enable, bit1 prio_mode (0 round-robin, 1 fixed, source 0 highest).
REQ-013 SHALL have grant_idx  out  2  index of the current or last granted source.
REQ-014 SHALL have busy  out  1  high while a packet is locked.
REQ-015 SHALL have pkt_cnt  out  NUM_SRC*32  per-source completed-packet counters.

Function
REQ-016 SHALL implement the states IDLE and LOCKED.
REQ-017 In IDLE with arb_enable=1 and any S_AXIS_TVALID high, SHALL pick a winner, register it in grant_idx and enter LOCKED on the next edge; arbitration latency is 1 cycle.
REQ-018 Round-robin: search SHALL start at (last winner+1) mod NUM_SRC; fixed: lowest-index valid source SHALL win.
REQ-019 In LOCKED, only the granted source SHALL receive S_AXIS_TREADY=1 and only when the output register is empty or M_AXIS_TREADY=1; all other TREADY bits SHALL be 0.
REQ-020 Output SHALL be a single registered stage; accepted beats appear on M_AXIS_* 1 cycle after the S-side handshake, sustaining one beat per cycle under continuous ready.
REQ-021 M_AXIS_TVALID/TDATA/TSTRB/TLAST SHALL hold stable while TVALID=1 and M_AXIS_TREADY=0.
REQ-022 Accepting a beat with TLAST=1 from the granted source SHALL return the FSM to IDLE on the same edge; the last winner updates to grant_idx.
REQ-023 No packet interleaving: a grant SHALL persist until its TLAST beat is accepted, regardless of other sources' valid or priority.
REQ-024 arb_enable deasserted mid-packet SHALL NOT truncate the packet; it blocks only new grants in IDLE.
REQ-025 In IDLE, all S_AXIS_TREADY SHALL be 0.
REQ-026 Granted source dropping TVALID mid-packet SHALL keep the lock; M_AXIS_TVALID falls after draining.
REQ-027 busy SHALL equal (state==LOCKED).
REQ-028 pkt_cnt[i] SHALL increment by 1 per accepted TLAST beat of source i and wrap 0xFFFFFFFF->0.

Reset
REQ-029 On AXIS_ARESETN low, SHALL asynchronously clear: state=IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TSTRB=0, S_AXIS_TREADY=0, grant_idx=0, last winner=NUM_SRC-1, busy=0, pkt_cnt=0.
REQ-030 Reset mid-packet SHALL discard the partial packet; first grant after release follows REQ-018 from the reset pointer.

Configuration
REQ-031 Macro AXIS_ARB_PKT_CNT_EN defined: pkt_cnt counters SHALL be implemented per REQ-028.
REQ-032 Macro undefined: pkt_cnt port SHALL remain and be tied to 0; no counter flops.

Structure
REQ-033 Package axis_arb_pkg SHALL hold the state enum, prio_mode encodings, config bit positions and MAX_SRC=4.
REQ-034 Sub-module axis_arb_rr_picker SHALL implement the combinational winner select (valids, last winner, mode -> winner, any).

Verification
REQ-035 Both sources continuously valid, 4-beat packets, round-robin, ready=1 -> grants 0,1,0,1; beats contiguous; no interleaving.
REQ-036 prio_mode=1, both valid, 3 packets each -> all three source-0 packets precede any source-1 packet.
REQ-037 Source 0 8-beat packet, M_AXIS_TREADY low on beats 3-5 -> output holds beat 3 data stable; all 8 beats delivered in order.
REQ-038 arb_enable cleared after beat 2 of 6 -> packet completes with TLAST; no new grant while disabled.
REQ-039 Reset asserted at beat 3 of 8 -> all outputs zero immediately; after release, source 0 granted first (pointer=1 of NUM_SRC=2 wraps to 0).
REQ-040 With AXIS_ARB_PKT_CNT_EN, 5 packets from source 1 -> pkt_cnt slice 1 = 5, slice 0 = 0; without the macro -> both 0.
